// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit feeding the architectural HI/LO registers.
// Radix-2 Booth multiply and restoring divide, one iteration per clock.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             MoveHi,
    input  logic             MoveLo,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic               is_div;
    logic               dz_flag;

    // Booth accumulator: {hi (WIDTH+1 bits), lo (WIDTH bits), q_minus_1}
    logic [2*WIDTH+1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot;

    logic               last_iter;
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     p_hi;
    logic [WIDTH:0]     booth_sum;
    logic [WIDTH-1:0]   dvs;
    logic [WIDTH:0]     shifted;
    logic               ge;
    logic [WIDTH-1:0]   quot_res;
    logic [WIDTH-1:0]   rem_res;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    assign state_dbg = state;
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (!Op) begin
                        next_state = MULT;
                    end else if (B == '0) begin
                        next_state = FINISH;
                    end else begin
                        next_state = DIV;
                    end
                end
            end
            MULT:    if (last_iter) next_state = FINISH;
            DIV:     if (last_iter) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Booth step: the add/subtract is WIDTH+1 bits so -2^(WIDTH-1) never overflows.
    always_comb begin
        m_ext = {opa[WIDTH-1], opa};
        p_hi  = acc[2*WIDTH+1:WIDTH+1];
        case (acc[1:0])
            2'b01:   booth_sum = p_hi + m_ext;
            2'b10:   booth_sum = p_hi - m_ext;
            default: booth_sum = p_hi;
        endcase
    end

    // Restoring step on magnitudes; the partial remainder always stays below dvs.
    always_comb begin
        dvs      = mag(opb);
        shifted  = {rem, quot[WIDTH-1]};
        ge       = (shifted >= {1'b0, dvs});
        quot_res = (opa[WIDTH-1] ^ opb[WIDTH-1]) ? -quot : quot;
        rem_res  = opa[WIDTH-1] ? -rem : rem;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            Busy    <= 1'b0;
            Done    <= 1'b0;
            DivZero <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            cnt     <= '0;
            opa     <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            dz_flag <= 1'b0;
            acc     <= '0;
            rem     <= '0;
            quot    <= '0;
        end else begin
            Done    <= 1'b0;
            DivZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        opa     <= A;
                        opb     <= B;
                        is_div  <= Op;
                        dz_flag <= Op && (B == '0);
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        acc     <= {{(WIDTH+1){1'b0}}, B, 1'b0};
                        rem     <= '0;
                        quot    <= mag(A);
                    end else begin
                        if (MoveHi) Hi <= A;
                        if (MoveLo) Lo <= A;
                    end
                end
                MULT: begin
                    acc <= {booth_sum[WIDTH], booth_sum, acc[WIDTH:1]};
                    cnt <= cnt + CW'(1);
                end
                DIV: begin
                    rem  <= ge ? (shifted[WIDTH-1:0] - dvs) : shifted[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], ge};
                    cnt  <= cnt + CW'(1);
                end
                FINISH: begin
                    Busy    <= 1'b0;
                    Done    <= 1'b1;
                    DivZero <= dz_flag;
                    if (!dz_flag) begin
                        if (is_div) begin
                            Hi <= rem_res;
                            Lo <= quot_res;
                        end else begin
                            Hi <= acc[2*WIDTH:WIDTH+1];
                            Lo <= acc[WIDTH:1];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: expected {DivZero, Hi, Lo} queued at issue,
// compared when Done is seen.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         Reset;
    logic         Start;
    logic         Op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         MoveHi;
    logic         MoveLo;
    logic         Busy;
    logic         Done;
    logic         DivZero;
    logic [W-1:0] Hi;
    logic [W-1:0] Lo;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*W:0] exp_q[$];
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;
    int           done_seen;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .MoveHi    (MoveHi),
        .MoveLo    (MoveLo),
        .Busy      (Busy),
        .Done      (Done),
        .DivZero   (DivZero),
        .Hi        (Hi),
        .Lo        (Lo),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W:0] exp_mult(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return {1'b0, p[63:0]};
    endfunction

    function automatic logic [2*W:0] exp_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Scoreboard side: every Done pops one expected result.
    always @(negedge clk) begin
        if (Done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                check("result", {DivZero, Hi, Lo}, exp_q.pop_front());
            end
        end
    end

    // Called just after a rising edge; returns just after the sampling edge E0.
    task automatic start_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic mh);
        logic [2*W:0] e;
        if (!op) e = exp_mult(a, b);
        else if (b == '0) e = {1'b1, model_hi, model_lo};
        else e = exp_div(a, b);
        exp_q.push_back(e);
        model_hi = e[2*W-1:W];
        model_lo = e[W-1:0];
        Start  = 1'b1;
        Op     = op;
        A      = a;
        B      = b;
        MoveHi = mh;
        @(posedge clk);
        #1;
        Start  = 1'b0;
        MoveHi = 1'b0;
        A      = $urandom;
        B      = $urandom;
        Op     = 1'($urandom_range(0, 1));
        check("busy_after_start", {64'd0, Busy}, 1);
    endtask

    task automatic wait_done(input int exp_lat, input bit check_clear);
        int n;
        for (n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (Done) break;
        end
        check("latency", n, exp_lat);
        if (check_clear) begin
            @(posedge clk);
            #1;
            check("done_clear", {Done, DivZero, Busy}, 0);
        end
    endtask

    task automatic move(input logic hi, input logic lo, input logic [W-1:0] val);
        MoveHi = hi;
        MoveLo = lo;
        A      = val;
        @(posedge clk);
        #1;
        MoveHi = 1'b0;
        MoveLo = 1'b0;
        if (hi) model_hi = val;
        if (lo) model_lo = val;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Op = 1'b0; A = '0; B = '0;
        MoveHi = 1'b0; MoveLo = 1'b0;
        model_hi = '0; model_lo = '0; done_seen = 0;
        #23;
        check("reset_outputs", {Busy, Done, DivZero, Hi, Lo}, 0);
        Reset = 1'b0;
        @(posedge clk);
        #1;

        // Multiply cases
        start_op(1'b0, 32'd7, 32'hFFFFFFFD, 1'b0);
        wait_done(33, 1);
        start_op(1'b0, 32'h80000000, 32'h80000000, 1'b0);
        wait_done(33, 1);
        start_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        wait_done(33, 1);

        // Divide cases, including the overflow corner
        start_op(1'b1, 32'hFFFFFFF9, 32'd2, 1'b0);
        wait_done(33, 1);
        start_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        wait_done(33, 1);

        // Preload, then divide by zero with a simultaneous MoveHi that must be dropped
        move(1'b1, 1'b0, 32'h11);
        move(1'b0, 1'b1, 32'h22);
        check("preload", {1'b0, Hi, Lo}, {1'b0, 32'h11, 32'h22});
        start_op(1'b1, 32'd5, 32'd0, 1'b1);
        wait_done(1, 1);

        // Asynchronous reset in the middle of a multiply
        start_op(1'b0, 32'h1234, 32'h5678, 1'b0);
        repeat (10) @(posedge clk);
        #3;
        Reset = 1'b1;
        #1;
        check("reset_mid_op", {Busy, Done, Hi, Lo}, 0);
        exp_q.delete();
        model_hi = '0;
        model_lo = '0;
        done_seen = 0;
        #10;
        Reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("no_done_after_reset", done_seen, 0);
        start_op(1'b0, 32'd3, 32'd4, 1'b0);
        wait_done(33, 1);

        // Start/MoveHi while busy are ignored; Hi holds until the result lands
        start_op(1'b0, 32'd100, 32'hFFFFFFFB, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        Start = 1'b1; MoveHi = 1'b1; Op = 1'b1; A = 32'hDEAD; B = 32'd0;
        @(posedge clk);
        #1;
        Start = 1'b0; MoveHi = 1'b0;
        check("hi_held_busy", {1'b0, Hi, 32'd0}, {1'b0, 32'd0, 32'd0});
        wait_done(28, 1);

        // MoveLo in IDLE
        move(1'b0, 1'b1, 32'hABCD);
        check("move_lo", {33'd0, Lo}, {33'd0, 32'hABCD});

        // Back-to-back issue in the Done cycle
        start_op(1'b0, 32'hFFFF0001, 32'd65536, 1'b0);
        wait_done(33, 0);
        start_op(1'b1, 32'd1000, 32'hFFFFFFF9, 1'b0);
        wait_done(33, 1);

        // Random mix
        for (int i = 0; i < 8; i++) begin
            logic         op;
            logic [W-1:0] a, b;
            op = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 2) == 0) b = W'($urandom_range(1, 9));
            if ($urandom_range(0, 3) == 0) b = -b;
            if (op && b == '0) b = 32'd1;
            start_op(op, a, b, 1'b0);
            wait_done(33, 1);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit on the datapath, directly downstream of the control FSM.
- Control issues Start with Op, then holds in a wait state until Done.
- Results go into the architectural HI/LO registers, read by the datapath for mfhi/mflo.
- DivZero feeds the control's exception path (cause write / EPC).

Parameters:
WIDTH, 32, operand width and width of each of Hi and Lo.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin operation; sampled only in IDLE.
- Op  in  1  0 = signed multiply, 1 = signed divide.
- A  in  WIDTH  multiplicand / dividend; also the source for MoveHi/MoveLo.
- B  in  WIDTH  multiplier / divisor.
- MoveHi  in  1  load Hi from A (mthi).
- MoveLo  in  1  load Lo from A (mtlo).
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse when Hi/Lo hold the new result.
- DivZero  out  1  one-cycle pulse, coincident with Done, on a divide by zero.
- Hi  out  WIDTH  HI register.
- Lo  out  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - Busy=0, Done=0, DivZero=0, Hi=0, Lo=0, iteration counter=0, state=IDLE.
  - An operation in flight is discarded; no Done is produced.
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - Start=1 at edge E0: latch A and B into internal operand registers, clear counter, Busy=1.
    - Op=0 -> MULT.
    - Op=1 with B!=0 -> DIV.
    - Op=1 with B=0 -> FINISH with the zero-divide flag set.
  - Start=0 with MoveHi=1: Hi<=A at that edge. MoveLo=1: Lo<=A. Both may be asserted together.
  - Start and Move asserted together: Start wins; the Move is dropped.
- MULT:
  - Radix-2 Booth, 2*WIDTH-bit accumulator.
  - One iteration per cycle; WIDTH iterations at edges E1..E_WIDTH; then -> FINISH.
- DIV:
  - Restoring division on operand magnitudes; WIDTH iterations at E1..E_WIDTH; then -> FINISH.
  - Quotient negated when operand signs differ.
  - Remainder takes the sign of the dividend.
  - -2^(WIDTH-1) / -1 yields Lo=0x80000000, Hi=0 with no flag.
- FINISH (edge after the last iteration): write Hi/Lo, Done=1, Busy=0, -> IDLE.
  - Multiply: Hi = upper WIDTH bits of the product, Lo = lower WIDTH bits.
  - Divide: Lo = quotient, Hi = remainder.
  - Zero divide: reached at E1; Hi/Lo unchanged; Done=1 and DivZero=1.
- Done and DivZero are high for exactly one cycle, then cleared on the next edge.
- Latency:
  - Mult/div: Done visible after edge E_(WIDTH+1), i.e. 33 edges after the Start sample for WIDTH=32.
  - Zero divide: Done visible after E1.
- While Busy:
  - Start, MoveHi and MoveLo are ignored.
  - Changes on A and B have no effect.
  - Hi and Lo hold their previous values until FINISH.
- Start sampled in the same cycle Done is high (back-to-back issue) is accepted, since the state is IDLE.
- All arithmetic is two's complement. Intermediate sums are WIDTH+1 bits wide so no carry is lost.

Test Plan:
- Multiply: A=7, B=0xFFFFFFFD (-3), Op=0, Start pulse -> Busy for 33 cycles; Done at edge 33; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; DivZero=0.
- Multiply: A=B=0x80000000 -> Hi=0x40000000, Lo=0x00000000. Then A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0, Lo=1.
- Divide: A=0xFFFFFFF9 (-7), B=2, Op=1 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - Then A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Divide by zero: Hi=0x11, Lo=0x22 preloaded via MoveHi/MoveLo; A=5, B=0, Op=1 -> Done and DivZero pulse at edge 1; Hi=0x11, Lo=0x22 unchanged.
- Reset asserted asynchronously at iteration 10 of a multiply -> Busy, Hi and Lo go to 0 immediately; no Done follows.
  - Next Start (A=3, B=4) -> Lo=12, Hi=0.
- Control interactions:
  - Start and MoveHi pulsed while Busy -> ignored; the result matches the original operands.
  - MoveLo with A=0xABCD in IDLE -> Lo=0xABCD next cycle.
  - Start issued the cycle Done is high -> accepted; the second result is correct.
